// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_port_arbiter_if
// Purpose  : Request, memory-handshake and result signals of the IF/MEM
//            shared memory port.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             IFReq;
  logic [WIDTH-1:0] IFAddr;
  logic             MemRead;
  logic             MemWrite;
  logic [WIDTH-1:0] DataAddr;
  logic [WIDTH-1:0] DataWData;
  logic             MemReady;
  logic [WIDTH-1:0] MemRData;
  logic [WIDTH-1:0] MemAddr;
  logic [WIDTH-1:0] MemWData;
  logic             MemRdEn;
  logic             MemWrEn;
  logic [WIDTH-1:0] Instr;
  logic [WIDTH-1:0] DataOut;
  logic             IFStall;
  logic             MEMStall;

  modport slave (
    input  IFReq, IFAddr, MemRead, MemWrite, DataAddr, DataWData,
           MemReady, MemRData,
    output MemAddr, MemWData, MemRdEn, MemWrEn, Instr, DataOut,
           IFStall, MEMStall
  );

  modport master (
    output IFReq, IFAddr, MemRead, MemWrite, DataAddr, DataWData,
           MemReady, MemRData,
    input  MemAddr, MemWData, MemRdEn, MemWrEn, Instr, DataOut,
           IFStall, MEMStall
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and
//            data access, with a bounded data-priority starvation guard.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 2
) (
  input  wire logic         CLK,
  input  wire logic         Reset,
  mem_port_arbiter_if.slave bus
);
  localparam int c_CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_BUSY   = 2'd1,
    DATA_BUSY = 2'd2
  } state_t;

  state_t             r_state,      w_state_nxt;
  logic [WIDTH-1:0]   r_mem_addr,   w_mem_addr_nxt;
  logic [WIDTH-1:0]   r_mem_wdata,  w_mem_wdata_nxt;
  logic               r_rd_en,      w_rd_en_nxt;
  logic               r_wr_en,      w_wr_en_nxt;
  logic [WIDTH-1:0]   r_instr,      w_instr_nxt;
  logic [WIDTH-1:0]   r_data_out,   w_data_out_nxt;
  logic [c_CNT_W-1:0] r_starve_cnt, w_starve_cnt_nxt;

  logic w_dreq;
  logic w_force_if;
  logic w_if_done;
  logic w_data_done;

  assign w_dreq      = bus.MemRead | bus.MemWrite;
  assign w_force_if  = bus.IFReq & (r_starve_cnt == c_STARVE_MAX);
  assign w_if_done   = (r_state == IF_BUSY) & bus.MemReady;
  assign w_data_done = (r_state == DATA_BUSY) & bus.MemReady;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_instr      <= '0;
      r_data_out   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_instr      <= w_instr_nxt;
      r_data_out   <= w_data_out_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_rd_en_nxt      = r_rd_en;
    w_wr_en_nxt      = r_wr_en;
    w_instr_nxt      = r_instr;
    w_data_out_nxt   = r_data_out;
    w_starve_cnt_nxt = r_starve_cnt;

    case (r_state)
      IDLE: begin
        if (w_dreq && !w_force_if) begin
          w_state_nxt     = DATA_BUSY;
          w_mem_addr_nxt  = bus.DataAddr;
          w_mem_wdata_nxt = bus.DataWData;
          // A combined read+write request is treated as a store.
          w_wr_en_nxt     = bus.MemWrite;
          w_rd_en_nxt     = ~bus.MemWrite;
          if (bus.IFReq && (r_starve_cnt < c_STARVE_MAX)) begin
            w_starve_cnt_nxt = r_starve_cnt + c_CNT_W'(1);
          end
        end else if (bus.IFReq) begin
          w_state_nxt      = IF_BUSY;
          w_mem_addr_nxt   = bus.IFAddr;
          w_rd_en_nxt      = 1'b1;
          w_wr_en_nxt      = 1'b0;
          w_starve_cnt_nxt = '0;
        end else begin
          w_rd_en_nxt = 1'b0;
          w_wr_en_nxt = 1'b0;
        end
      end
      IF_BUSY: begin
        if (bus.MemReady) begin
          w_state_nxt = IDLE;
          w_rd_en_nxt = 1'b0;
          w_wr_en_nxt = 1'b0;
          w_instr_nxt = bus.MemRData;
        end
      end
      DATA_BUSY: begin
        if (bus.MemReady) begin
          w_state_nxt = IDLE;
          w_rd_en_nxt = 1'b0;
          w_wr_en_nxt = 1'b0;
          if (!r_wr_en) begin
            w_data_out_nxt = bus.MemRData;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rd_en_nxt = 1'b0;
        w_wr_en_nxt = 1'b0;
      end
    endcase
  end

  assign bus.MemAddr  = r_mem_addr;
  assign bus.MemWData = r_mem_wdata;
  assign bus.MemRdEn  = r_rd_en;
  assign bus.MemWrEn  = r_wr_en;

  // Pass read data through in the completion cycle so the pipeline captures
  // it on the same edge its stall drops.
  assign bus.Instr    = w_if_done ? bus.MemRData : r_instr;
  assign bus.DataOut  = (w_data_done && !r_wr_en) ? bus.MemRData : r_data_out;
  assign bus.IFStall  = bus.IFReq & ~w_if_done;
  assign bus.MEMStall = w_dreq & ~w_data_done;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a latency-controlled
//            memory responder.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  logic clk;
  logic Reset;

  mem_port_arbiter_if #(.WIDTH(32)) bus ();

  mem_port_arbiter #(.WIDTH(32), .STARVE_MAX(2)) dut (
    .CLK   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
  } acc_t;

  acc_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat_d = 0;
  bit          mem_auto = 1'b1;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_dout  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C02_0004 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_size(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() <= n) return;
      tick();
    end
    check("queue_timeout", exp_q.size(), n);
    exp_q.delete();
  endtask

  task automatic wait_busy(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus.MemRdEn || bus.MemWrEn) return;
      tick();
    end
    check("busy_timeout", 0, 1);
  endtask

  // Memory model: MemReady rises in busy cycle lat_d+1.
  initial begin
    int cnt;
    cnt = 0;
    bus.MemReady = 1'b0;
    bus.MemRData = 32'hBAD0_0000;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        if (Reset || !(bus.MemRdEn || bus.MemWrEn)) begin
          cnt = 0;
          bus.MemReady = 1'b0;
          bus.MemRData = 32'hBAD0_0000;
        end else begin
          cnt++;
          if (cnt > lat_d) begin
            bus.MemReady = 1'b1;
            bus.MemRData = mem_word(bus.MemAddr);
          end else begin
            bus.MemReady = 1'b0;
            bus.MemRData = 32'hBAD0_0000 | 32'(cnt);
          end
        end
      end
    end
  end

  // Scoreboard monitor sampling on the falling edge.
  initial begin
    int   blen;
    bit   busy;
    bit   if_done;
    bit   d_done;
    acc_t f;
    blen = 0;
    forever begin
      @(negedge clk);
      if (Reset) begin
        blen = 0;
      end else begin
        busy    = bus.MemRdEn || bus.MemWrEn;
        if_done = 1'b0;
        d_done  = 1'b0;
        if (busy && exp_q.size() == 0) begin
          check("busy_without_request", 32'(busy), 0);
        end else if (busy) begin
          f = exp_q[0];
          blen++;
          check("mem_addr", bus.MemAddr, f.addr);
          check("rd_en", 32'(bus.MemRdEn), 32'(!f.wr));
          check("wr_en", 32'(bus.MemWrEn), 32'(f.wr));
          if (f.wr) check("mem_wdata", bus.MemWData, f.wdata);
          if (bus.MemReady) begin
            if_done = f.is_if;
            d_done  = !f.is_if;
            check("busy_len", blen, lat_d + 1);
            if (f.is_if) begin
              exp_instr = mem_word(f.addr);
              check("instr_pass", bus.Instr, exp_instr);
              check("dout_hold", bus.DataOut, exp_dout);
            end else begin
              if (!f.wr) exp_dout = mem_word(f.addr);
              check("dout_pass", bus.DataOut, exp_dout);
              check("instr_hold", bus.Instr, exp_instr);
            end
            void'(exp_q.pop_front());
            blen = 0;
          end
        end
        if (!(busy && bus.MemReady)) begin
          check("instr_hold", bus.Instr, exp_instr);
          check("dout_hold", bus.DataOut, exp_dout);
        end
        check("if_stall", 32'(bus.IFStall), 32'(bus.IFReq && !if_done));
        check("mem_stall", 32'(bus.MEMStall),
              32'((bus.MemRead || bus.MemWrite) && !d_done));
      end
    end
  end

  initial begin
    Reset         = 1'b1;
    bus.IFReq     = 1'b0;
    bus.IFAddr    = '0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.DataAddr  = '0;
    bus.DataWData = '0;
    tick();
    tick();
    check("rst_addr", bus.MemAddr, 0);
    check("rst_wdata", bus.MemWData, 0);
    check("rst_rden", 32'(bus.MemRdEn), 0);
    check("rst_wren", 32'(bus.MemWrEn), 0);
    check("rst_instr", bus.Instr, 0);
    check("rst_dout", bus.DataOut, 0);
    Reset = 1'b0;
    tick();

    // Single fetch, minimum latency.
    lat_d = 0;
    exp_q.push_back('{1'b1, 32'h40, 32'h0, 1'b0});
    bus.IFReq = 1'b1; bus.IFAddr = 32'h40;
    wait_size(0, 20);
    bus.IFReq = 1'b0;
    check("t1_instr", bus.Instr, 32'h8C02_0004);
    tick();

    // Simultaneous requests: data wins, IF follows after one idle cycle.
    exp_q.push_back('{1'b0, 32'h100, 32'h0, 1'b0});
    exp_q.push_back('{1'b1, 32'h44, 32'h0, 1'b0});
    bus.IFReq = 1'b1; bus.IFAddr = 32'h44;
    bus.MemRead = 1'b1; bus.DataAddr = 32'h100;
    wait_size(1, 20);
    check("t2_idle_gap", 32'(bus.MemRdEn), 0);
    bus.MemRead = 1'b0;
    tick();
    check("t2_if_grant", 32'(bus.MemRdEn), 1);
    check("t2_if_addr", bus.MemAddr, 32'h44);
    wait_size(0, 20);
    bus.IFReq = 1'b0;
    tick();

    // Continuous contention: two data grants, forced fetch, data again.
    exp_q.push_back('{1'b0, 32'h104, 32'h0, 1'b0});
    exp_q.push_back('{1'b0, 32'h104, 32'h0, 1'b0});
    exp_q.push_back('{1'b1, 32'h48, 32'h0, 1'b0});
    exp_q.push_back('{1'b0, 32'h104, 32'h0, 1'b0});
    bus.IFReq = 1'b1; bus.IFAddr = 32'h48;
    bus.MemRead = 1'b1; bus.DataAddr = 32'h104;
    wait_size(0, 40);
    bus.IFReq = 1'b0; bus.MemRead = 1'b0;
    tick();

    // Slow store: everything held for six busy cycles.
    lat_d = 5;
    exp_q.push_back('{1'b0, 32'h200, 32'hDEAD_BEEF, 1'b1});
    bus.MemWrite = 1'b1; bus.DataAddr = 32'h200; bus.DataWData = 32'hDEAD_BEEF;
    wait_size(0, 30);
    bus.MemWrite = 1'b0;
    tick();

    // Reset in the third busy cycle of a fetch.
    lat_d = 10;
    exp_q.push_back('{1'b1, 32'h80, 32'h0, 1'b0});
    bus.IFReq = 1'b1; bus.IFAddr = 32'h80;
    wait_busy(10);
    tick();
    tick();
    #1;
    Reset = 1'b1;
    bus.IFReq = 1'b0;
    exp_q.delete();
    exp_instr = '0;
    exp_dout  = '0;
    #1;
    check("t5_rden", 32'(bus.MemRdEn), 0);
    check("t5_instr", bus.Instr, 0);
    check("t5_addr", bus.MemAddr, 0);
    tick();
    Reset = 1'b0;
    mem_auto = 1'b0;
    tick();
    bus.MemReady = 1'b1;
    bus.MemRData = 32'hFFFF_FFFF;
    tick();
    check("t5_late_instr", bus.Instr, 0);
    check("t5_late_dout", bus.DataOut, 0);
    check("t5_late_rden", 32'(bus.MemRdEn), 0);
    bus.MemReady = 1'b0;
    mem_auto = 1'b1;
    tick();

    // Read+write is a store; pending fetch withdrawn mid-access.
    lat_d = 3;
    exp_q.push_back('{1'b0, 32'h300, 32'hCAFE_F00D, 1'b1});
    bus.IFReq = 1'b1; bus.IFAddr = 32'h90;
    bus.MemRead = 1'b1; bus.MemWrite = 1'b1;
    bus.DataAddr = 32'h300; bus.DataWData = 32'hCAFE_F00D;
    wait_busy(10);
    check("t6_wren", 32'(bus.MemWrEn), 1);
    check("t6_rden", 32'(bus.MemRdEn), 0);
    tick();
    bus.IFReq = 1'b0;
    #1;
    check("t6_ifstall", 32'(bus.IFStall), 0);
    wait_size(0, 20);
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    tick();

    // Fetch withdrawn mid-access still completes and updates Instr.
    exp_q.push_back('{1'b1, 32'h94, 32'h0, 1'b0});
    bus.IFReq = 1'b1; bus.IFAddr = 32'h94;
    wait_busy(10);
    tick();
    bus.IFReq = 1'b0;
    wait_size(0, 20);
    tick();
    check("t6b_instr", bus.Instr, mem_word(32'h94));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port memory between the instruction-fetch (IF) requester and the data-access (MEM stage) requester of the pipelined CPU.
- Latches the winning request and holds the memory handshake until the memory returns MemReady.
- Returns read data to the owning requester and drives per-requester stall signals; the pipeline ORs these into its PCWrite/IFWrite gating.
- Prevents IF starvation with a bounded data-priority counter.

Parameters:
WIDTH, 32, address/data width in bits
STARVE_MAX, 2, consecutive data grants issued while IFReq is pending before IF is forced to win

Ports:
CLK  input  1  clock; all state updates on posedge
Reset  input  1  asynchronous, active-high reset
IFReq  input  1  instruction fetch request
IFAddr  input  WIDTH  fetch address (PC)
MemRead  input  1  data load request
MemWrite  input  1  data store request
DataAddr  input  WIDTH  data address
DataWData  input  WIDTH  store data
MemReady  input  1  memory completion strobe for the current access
MemRData  input  WIDTH  memory read data, valid when MemReady=1
MemAddr  output  WIDTH  registered address to memory
MemWData  output  WIDTH  registered store data to memory
MemRdEn  output  1  registered read enable
MemWrEn  output  1  registered write enable
Instr  output  WIDTH  fetched instruction
DataOut  output  WIDTH  load result
IFStall  output  1  IF must hold (PC/IF register not written)
MEMStall  output  1  pipeline must freeze at the MEM stage and above

Behaviour:
- Reset (async, any time, including mid-transaction): state=IDLE; MemAddr, MemWData, Instr, DataOut = 0; MemRdEn=MemWrEn=0; starve_cnt=0. Any in-flight access is abandoned. MemReady arriving after reset is ignored.
- DReq = MemRead|MemWrite. If MemRead and MemWrite are both 1, the access is a write.
- States: IDLE, IF_BUSY, DATA_BUSY.
- IDLE:
  - if DReq and not (IFReq and starve_cnt==STARVE_MAX) -> DATA_BUSY; latch MemAddr=DataAddr and MemWData=DataWData; set MemWrEn=MemWrite and MemRdEn=~MemWrite.
  - else if IFReq -> IF_BUSY; latch MemAddr=IFAddr; set MemRdEn=1, MemWrEn=0.
  - else stay in IDLE; enables 0.
  - MemReady in IDLE is ignored.
- Starvation counter:
  - On a data grant with IFReq=1: starve_cnt increments, saturating at STARVE_MAX.
  - On an IF grant: starve_cnt clears to 0.
  - On a data grant with IFReq=0: starve_cnt is unchanged.
- IF_BUSY / DATA_BUSY:
  - Latched address, data and enables are held stable until MemReady is sampled 1.
  - On that edge: enables -> 0 and state -> IDLE.
  - Instr (from IF_BUSY) or DataOut (from a read in DATA_BUSY) is registered from MemRData; a write leaves DataOut unchanged.
  - Every grant passes through IDLE for exactly one cycle after completion; the minimum access is 2 cycles (grant edge, then MemReady one cycle later).
- Stalls (combinational):
  - IFStall = IFReq & ~(state==IF_BUSY & MemReady).
  - MEMStall = DReq & ~(state==DATA_BUSY & MemReady).
- Result visibility:
  - During the completion cycle, Instr/DataOut combinationally pass MemRData, so the pipeline captures the value on the same edge the stall drops.
  - Otherwise Instr/DataOut hold their last registered value.
- Request withdrawn mid-transaction (e.g. a flush): the latched access still completes. A store is performed; read data is still registered; no stall is asserted for the withdrawn requester.
- Simultaneous IFReq and DReq in IDLE with starve_cnt<STARVE_MAX: data wins.

Test Plan:
- Reset, then IFReq=1, IFAddr=0x40, MemReady one cycle after the grant with MemRData=0x8C020004 -> MemRdEn=1 for 1 cycle; IFStall low in the completion cycle; Instr=0x8C020004.
- IFReq=1 and MemRead=1 with DataAddr=0x100 simultaneously (starve_cnt=0) -> data granted first, MemAddr=0x100; IF granted after one IDLE cycle; IFStall high throughout the data access.
- IFReq held high with continuous DReq, STARVE_MAX=2 -> two data grants, then a forced IF grant with starve_cnt 2->0; data grant resumes afterwards.
- MemWrite=1, DataAddr=0x200, DataWData=0xDEADBEEF, MemReady delayed 5 cycles -> MemWrEn, MemAddr and MemWData stable for all 6 busy cycles; MEMStall high until the completion cycle; DataOut unchanged.
- Reset asserted in the 3rd cycle of an IF_BUSY access -> MemRdEn=0 immediately; state IDLE; Instr=0; a later MemReady pulse produces no output change.
- MemRead and MemWrite both 1 -> MemWrEn=1, MemRdEn=0; IFReq dropped mid-access -> the access still completes and IFStall stays 0.
